// File: rtl/hex_display_bank_if.sv
// Load handshake between the producer of a packed nibble word and the display bank.
interface hex_display_bank_if #(
    parameter int DIGITS = 4
) ();
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                load_ack;

    modport master (output value, output load, input load_ack);
    modport slave  (input value, input load, output load_ack);
endinterface

// File: rtl/hex_display_bank.sv
// Bank of DIGITS seven-segment hex displays: latches a nibble word on load and drives
// active-low segments from flops, with leading-zero blanking and per-digit blinking.
module hex_display_bank #(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    hex_display_bank_if.slave     bus,
    input  logic                  blank_zeros,
    input  logic                  blink_en,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   hex
);
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [4*DIGITS-1:0] latch_q, latch_d;
    logic                load_ack_q, load_ack_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;

    // Active-high segment pattern, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            4'hF:    seg = 7'b1110001;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    // Next state for the latch, the load acknowledge and the free-running blink timebase
    always_comb begin
        latch_d    = latch_q;
        load_ack_d = bus.load;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        if (bus.load) begin
            latch_d = bus.value;
        end else begin
            latch_d = latch_q;
        end
        if (cnt_q == CNT_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
        end
    end

    // Next display word: walk from the top digit so the zero run is known per digit
    always_comb begin : p_display
        logic run_zero_s;
        logic lz_blank_s;
        logic blink_blank_s;
        hex_d         = {(7*DIGITS){1'b1}};
        run_zero_s    = 1'b1;
        lz_blank_s    = 1'b0;
        blink_blank_s = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero_s    = run_zero_s & (latch_q[4*i +: 4] == 4'h0);
            lz_blank_s    = blank_zeros & run_zero_s & (i != 0);
            blink_blank_s = blink_en & phase_q & blink_mask[i];
            if (lz_blank_s | blink_blank_s) begin
                hex_d[7*i +: 7] = 7'h7F;
            end else begin
                hex_d[7*i +: 7] = ~seg_decode(latch_q[4*i +: 4]);
            end
        end
    end

    // State registers; reset leaves the display dark and the timebase at phase 0
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q    <= {(4*DIGITS){1'b0}};
            load_ack_q <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            phase_q    <= 1'b0;
            hex_q      <= {(7*DIGITS){1'b1}};
        end else begin
            latch_q    <= latch_d;
            load_ack_q <= load_ack_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            hex_q      <= hex_d;
        end
    end

    assign hex          = hex_q;
    assign bus.load_ack = load_ack_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank: 4-digit build with a short blink period,
// plus 1-digit and 8-digit builds for the full nibble sweep.
module tb_hex_display_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic        bz;
    logic        ben;
    logic [3:0]  bmask;
    logic [27:0] hex4;
    logic [6:0]  hex1;
    logic [55:0] hex8;
    logic        aux_zero;
    logic [7:0]  aux_mask;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-written active-low patterns, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] BL = 7'h7F;

    hex_display_bank_if #(.DIGITS(4)) if4 ();
    hex_display_bank_if #(.DIGITS(1)) if1 ();
    hex_display_bank_if #(.DIGITS(8)) if8 ();

    hex_display_bank #(.DIGITS(4), .BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .bus(if4), .blank_zeros(bz), .blink_en(ben),
        .blink_mask(bmask), .hex(hex4)
    );
    hex_display_bank #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .blank_zeros(aux_zero), .blink_en(aux_zero),
        .blink_mask(aux_mask[0:0]), .hex(hex1)
    );
    hex_display_bank #(.DIGITS(8)) dut8 (
        .clk(clk), .rst(rst), .bus(if8), .blank_zeros(aux_zero), .blink_en(aux_zero),
        .blink_mask(aux_mask), .hex(hex8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (hex4 !== {28{1'b1}}) begin n_fail++; $display("FAIL reset_hex: got %h want %h", hex4, {28{1'b1}}); end
        n_checks++;
        if (if4.load_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", if4.load_ack); end
        n_checks++;
        if (hex8 !== {56{1'b1}}) begin n_fail++; $display("FAIL reset_hex8: got %h want %h", hex8, {56{1'b1}}); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (hex4 !== {SEG[0], SEG[0], SEG[0], SEG[0]}) begin
            n_fail++; $display("FAIL first_display: got %h want %h", hex4, {SEG[0], SEG[0], SEG[0], SEG[0]});
        end
    endtask

    task automatic test_load();
        if4.value = 16'hA5C3;
        if4.load  = 1'b1;
        tick();
        n_checks++;
        if (if4.load_ack !== 1'b1) begin n_fail++; $display("FAIL load_ack_pulse: got %b want 1", if4.load_ack); end
        n_checks++;
        if (hex4 !== {SEG[0], SEG[0], SEG[0], SEG[0]}) begin
            n_fail++; $display("FAIL load_latency: got %h want %h", hex4, {SEG[0], SEG[0], SEG[0], SEG[0]});
        end
        if4.load  = 1'b0;
        if4.value = 16'hFFFF;
        tick();
        n_checks++;
        if (if4.load_ack !== 1'b0) begin n_fail++; $display("FAIL load_ack_end: got %b want 0", if4.load_ack); end
        n_checks++;
        if (hex4 !== {SEG[10], SEG[5], SEG[12], SEG[3]}) begin
            n_fail++; $display("FAIL load_a5c3: got %h want %h", hex4, {SEG[10], SEG[5], SEG[12], SEG[3]});
        end
        tick();
        n_checks++;
        if (hex4 !== {SEG[10], SEG[5], SEG[12], SEG[3]}) begin
            n_fail++; $display("FAIL value_ignored: got %h want %h", hex4, {SEG[10], SEG[5], SEG[12], SEG[3]});
        end
    endtask

    task automatic test_back_to_back();
        if4.value = 16'h1111;
        if4.load  = 1'b1;
        tick();
        n_checks++;
        if (if4.load_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1: got %b want 1", if4.load_ack); end
        if4.value = 16'h2222;
        tick();
        n_checks++;
        if (if4.load_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack2: got %b want 1", if4.load_ack); end
        n_checks++;
        if (hex4 !== {SEG[1], SEG[1], SEG[1], SEG[1]}) begin
            n_fail++; $display("FAIL b2b_hex1: got %h want %h", hex4, {SEG[1], SEG[1], SEG[1], SEG[1]});
        end
        if4.load = 1'b0;
        tick();
        n_checks++;
        if (if4.load_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack3: got %b want 0", if4.load_ack); end
        n_checks++;
        if (hex4 !== {SEG[2], SEG[2], SEG[2], SEG[2]}) begin
            n_fail++; $display("FAIL b2b_hex2: got %h want %h", hex4, {SEG[2], SEG[2], SEG[2], SEG[2]});
        end
    endtask

    task automatic load4(input logic [15:0] v);
        if4.value = v;
        if4.load  = 1'b1;
        tick();
        if4.load  = 1'b0;
        tick();
    endtask

    task automatic test_blank_zeros();
        bz = 1'b1;
        load4(16'h0070);
        n_checks++;
        if (hex4 !== {BL, BL, SEG[7], SEG[0]}) begin
            n_fail++; $display("FAIL lz_0070: got %h want %h", hex4, {BL, BL, SEG[7], SEG[0]});
        end
        load4(16'h0000);
        n_checks++;
        if (hex4 !== {BL, BL, BL, SEG[0]}) begin
            n_fail++; $display("FAIL lz_0000: got %h want %h", hex4, {BL, BL, BL, SEG[0]});
        end
        bz = 1'b0;
        tick();
        n_checks++;
        if (hex4 !== {SEG[0], SEG[0], SEG[0], SEG[0]}) begin
            n_fail++; $display("FAIL lz_live_off: got %h want %h", hex4, {SEG[0], SEG[0], SEG[0], SEG[0]});
        end
        bz = 1'b1;
        load4(16'h1000);
        n_checks++;
        if (hex4 !== {SEG[1], SEG[0], SEG[0], SEG[0]}) begin
            n_fail++; $display("FAIL lz_1000: got %h want %h", hex4, {SEG[1], SEG[0], SEG[0], SEG[0]});
        end
        load4(16'h0102);
        n_checks++;
        if (hex4 !== {BL, SEG[1], SEG[0], SEG[2]}) begin
            n_fail++; $display("FAIL lz_0102: got %h want %h", hex4, {BL, SEG[1], SEG[0], SEG[2]});
        end
        bz = 1'b0;
    endtask

    task automatic test_load_reset();
        rst       = 1'b1;
        if4.value = 16'hFFFF;
        if4.load  = 1'b1;
        tick();
        n_checks++;
        if (if4.load_ack !== 1'b0) begin n_fail++; $display("FAIL rst_load_ack: got %b want 0", if4.load_ack); end
        n_checks++;
        if (hex4 !== {28{1'b1}}) begin n_fail++; $display("FAIL rst_load_hex: got %h want %h", hex4, {28{1'b1}}); end
        rst      = 1'b0;
        if4.load = 1'b0;
        tick();
        n_checks++;
        if (if4.load_ack !== 1'b0) begin n_fail++; $display("FAIL rst_load_ack2: got %b want 0", if4.load_ack); end
        n_checks++;
        if (hex4 !== {SEG[0], SEG[0], SEG[0], SEG[0]}) begin
            n_fail++; $display("FAIL rst_load_latch: got %h want %h", hex4, {SEG[0], SEG[0], SEG[0], SEG[0]});
        end
    endtask

    // Edge t after the reset edge: phase after edge m is (m/4)%2, shown on HEX one edge later.
    task automatic test_blink();
        logic [27:0] exp;
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        if4.value = 16'h1234;
        if4.load  = 1'b1;
        ben       = 1'b1;
        bmask     = 4'b0101;
        for (int t = 1; t <= 13; t++) begin
            tick();
            if4.load = 1'b0;
            if (t >= 2) begin
                exp = ((((t - 1) / 4) % 2) == 1) ? {SEG[1], BL, SEG[3], BL} : {SEG[1], SEG[2], SEG[3], SEG[4]};
                n_checks++;
                if (hex4 !== exp) begin n_fail++; $display("FAIL blink_t%0d: got %h want %h", t, hex4, exp); end
            end
        end
    endtask

    task automatic test_reset_mid_blink();
        logic [27:0] exp;
        rst = 1'b1;
        tick();
        n_checks++;
        if (hex4 !== {28{1'b1}}) begin n_fail++; $display("FAIL midblink_rst_hex: got %h want %h", hex4, {28{1'b1}}); end
        rst       = 1'b0;
        if4.value = 16'h1234;
        if4.load  = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if4.load = 1'b0;
            if (t >= 2) begin
                exp = (t >= 5) ? {SEG[1], BL, SEG[3], BL} : {SEG[1], SEG[2], SEG[3], SEG[4]};
                n_checks++;
                if (hex4 !== exp) begin n_fail++; $display("FAIL midblink_t%0d: got %h want %h", t, hex4, exp); end
            end
        end
        ben = 1'b0;
        tick();
        n_checks++;
        if (hex4 !== {SEG[1], SEG[2], SEG[3], SEG[4]}) begin
            n_fail++; $display("FAIL blink_off: got %h want %h", hex4, {SEG[1], SEG[2], SEG[3], SEG[4]});
        end
    endtask

    task automatic test_sweep();
        logic [31:0] v8;
        logic [55:0] exp8;
        logic [3:0]  nib;
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 8; i++) begin
                nib            = 4'(n + i);
                v8[4*i +: 4]   = nib;
                exp8[7*i +: 7] = SEG[nib];
            end
            if1.value = 4'(n);
            if8.value = v8;
            if1.load  = 1'b1;
            if8.load  = 1'b1;
            tick();
            if1.load = 1'b0;
            if8.load = 1'b0;
            tick();
            n_checks++;
            if (hex1 !== SEG[n]) begin n_fail++; $display("FAIL sweep1_%0d: got %h want %h", n, hex1, SEG[n]); end
            n_checks++;
            if (hex8 !== exp8) begin n_fail++; $display("FAIL sweep8_%0d: got %h want %h", n, hex8, exp8); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        bz        = 1'b0;
        ben       = 1'b0;
        bmask     = 4'b0000;
        aux_zero  = 1'b0;
        aux_mask  = 8'h00;
        if4.value = 16'h0000;
        if4.load  = 1'b0;
        if1.value = 4'h0;
        if1.load  = 1'b0;
        if8.value = 32'h0000_0000;
        if8.load  = 1'b0;
        test_reset();
        test_load();
        test_back_to_back();
        test_blank_zeros();
        test_load_reset();
        test_blink();
        test_reset_mid_blink();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
